imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
// - Writer side of the instruction-memory interface the IFU reads from: receives a byte stream
//   over a valid/ready handshake, packs big-endian 32-bit words and writes them to imem.
// - Holds the core in reset (cpu_hold) until a complete, valid program image has been written.
// - Sits between the host/boot byte source and the imem write port, beside the mips top.
// PARAMETERS
// - ADDR_W     10     imem word-address width (1024 words; word address = byte address[11:2])
// - SYNC_BYTE  8'hA5  frame start marker
// PORTS
// - clk        in   1       single clock, rising edge
// - reset      in   1       synchronous, active-high
// - in_valid   in   1       byte source has in_data
// - in_data    in   8       stream byte
// - in_ready   out  1       loader accepts byte; transfer when in_valid & in_ready
// - im_we      out  1       imem write strobe, one cycle per word
// - im_addr    out  ADDR_W  imem word address
// - im_wdata   out  32      imem write data
// - cpu_hold   out  1       1 = keep core in reset
// - done       out  1       one-cycle pulse on successful load
// - err_ovf    out  1       sticky: frame word count > 2**ADDR_W
// - err_csum   out  1       sticky: checksum mismatch (only with LOADER_CSUM_EN)
// BEHAVIOUR
// - Reset: state=IDLE, in_ready=1, im_we=0, im_addr=0, im_wdata=0, cpu_hold=1, done=0,
//   err_ovf=0, err_csum=0, loaded=0, byte/word counters=0.
// - Frame: SYNC_BYTE, CNT_HI, CNT_LO, then CNT words x 4 bytes MSB first, [CSUM byte].
// - FSM: IDLE -> CNT_HI -> CNT_LO -> DATA -> (CSUM) -> IDLE; advances only on handshake.
//   IDLE: non-sync bytes consumed and dropped. Sync byte: cpu_hold=1, loaded=0, errors cleared,
//   word index=0, byte lane=0.
//   CNT_LO: CNT==0 -> finish immediately (CSUM state if enabled, else IDLE with success).
//   DATA: bytes shift into 32-bit accumulator; on 4th byte handshake, next cycle im_we=1,
//   im_addr=word index, im_wdata=word (latency 1 cycle), index increments.
// - in_ready=1 in every state; loader never back-pressures (imem write is single-cycle).
// - Word index >= 2**ADDR_W: bytes consumed, no im_we, err_ovf=1; no address wrap-around.
// - Success (last word or CSUM ok): done=1 for exactly one cycle, loaded=1, cpu_hold=0 from
//   the same cycle as done. Success with err_ovf=1 still releases cpu_hold (truncated image).
// - Final im_we and done coincide if last data byte ends the frame (no CSUM).
// - Sync byte arriving inside DATA is treated as data, not resync.
// - reset mid-frame: returns to reset values; partially written imem words are not undone.
// - cpu_hold = ~loaded; load failure (csum) leaves cpu_hold=1 until a good frame.
// CONFIGURATION
// - LOADER_CSUM_EN defined: after DATA (or CNT==0) enter CSUM; expect XOR of all bytes from
//   CNT_HI through last data byte. Match -> success. Mismatch -> err_csum=1, done=0,
//   loaded=0, cpu_hold stays 1, return to IDLE. Words already written remain in imem.
// - LOADER_CSUM_EN undefined: no CSUM state, err_csum tied 0, success after last word.
// TESTING
// - Reset, stream A5 00 01 12 34 56 78 -> one im_we, addr 0, wdata 32'h12345678; done pulse;
//   cpu_hold 1->0. (With EN append csum 8'h09 (00^01^12^34^56^78); with EN absent no extra byte.)
// - Bytes 00 FF before A5 00 02 + 8 bytes -> leading bytes dropped; writes at addr 0 and 1.
// - A5 00 00 (+ csum 00 with EN) -> no im_we, done pulse, cpu_hold=0.
// - ADDR_W=2, CNT=5 -> writes addr 0..3 only, err_ovf=1 after 5th word, done still pulses.
// - LOADER_CSUM_EN, wrong csum byte -> err_csum=1, no done, cpu_hold stays 1; resend good
//   frame -> err_csum cleared at sync, done pulses.
// - Assert reset after 2 data bytes -> all outputs at reset values next cycle; new frame works.

Source files
------------

// File: rtl/imem_loader.sv
`timescale 1ns/1ps
// imem_loader: packs a framed byte stream into big-endian 32-bit imem words and holds the
// core in reset until a complete image is written. Optional trailing checksum: LOADER_CSUM_EN.
module imem_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err_ovf,
  output logic              err_csum
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_HI,
    S_CNT_LO,
    S_DATA,
    S_CSUM
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] word_idx;
  logic [1:0]       lane;
  logic [23:0]      acc;

  logic             xfer;
  logic             cnt_zero;
  logic             last_word;
  logic             idx_ovf;
  logic [31:0]      word;

  assign xfer      = in_valid & in_ready;
  assign word      = {acc, in_data};
  assign cnt_zero  = ({cnt[15:8], in_data} == 16'd0);
  assign last_word = (17'(word_idx) + 17'd1) == 17'(cnt);
  // Words past the end of imem are swallowed instead of wrapping onto low addresses.
  assign idx_ovf   = 32'(word_idx) >= DEPTH;

`ifdef LOADER_CSUM_EN
  logic [7:0] csum;
`else
  assign err_csum = 1'b0;
`endif

  // cpu_hold doubles as the inverted "image loaded" flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      in_ready <= 1'b1;
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_wdata <= '0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      err_ovf  <= 1'b0;
      cnt      <= '0;
      word_idx <= '0;
      lane     <= '0;
      acc      <= '0;
`ifdef LOADER_CSUM_EN
      err_csum <= 1'b0;
      csum     <= '0;
`endif
    end else begin
      in_ready <= 1'b1;
      im_we    <= 1'b0;
      done     <= 1'b0;
      if (xfer) begin
        unique case (state)
          S_IDLE: begin
            if (in_data == SYNC_BYTE) begin
              state    <= S_CNT_HI;
              cpu_hold <= 1'b1;
              err_ovf  <= 1'b0;
              word_idx <= '0;
              lane     <= '0;
`ifdef LOADER_CSUM_EN
              err_csum <= 1'b0;
              csum     <= '0;
`endif
            end
          end

          S_CNT_HI: begin
            cnt[15:8] <= in_data;
            state     <= S_CNT_LO;
`ifdef LOADER_CSUM_EN
            csum      <= csum ^ in_data;
`endif
          end

          S_CNT_LO: begin
            cnt[7:0] <= in_data;
`ifdef LOADER_CSUM_EN
            csum     <= csum ^ in_data;
`endif
            if (cnt_zero) begin
`ifdef LOADER_CSUM_EN
              state    <= S_CSUM;
`else
              state    <= S_IDLE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
`endif
            end else begin
              state <= S_DATA;
            end
          end

          S_DATA: begin
            acc  <= {acc[15:0], in_data};
            lane <= lane + 2'd1;
`ifdef LOADER_CSUM_EN
            csum <= csum ^ in_data;
`endif
            if (lane == 2'd3) begin
              if (idx_ovf) begin
                err_ovf <= 1'b1;
              end else begin
                im_we    <= 1'b1;
                im_addr  <= word_idx[ADDR_W-1:0];
                im_wdata <= word;
              end
              word_idx <= word_idx + 16'd1;
              if (last_word) begin
`ifdef LOADER_CSUM_EN
                state    <= S_CSUM;
`else
                state    <= S_IDLE;
                done     <= 1'b1;
                cpu_hold <= 1'b0;
`endif
              end
            end
          end

`ifdef LOADER_CSUM_EN
          S_CSUM: begin
            state <= S_IDLE;
            if (in_data == csum) begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              err_csum <= 1'b1;
            end
          end
`endif

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
